// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Reads are combinational and see a same-cycle matching commit (bypass);
// renames become visible only after the clock edge.
`timescale 1ns/1ps
module reg_rename_file #(
    parameter int unsigned ROB_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    output logic [31:0]      rs1_val,
    output logic [ROB_W-1:0] rs1_tag,
    output logic [31:0]      rs2_val,
    output logic [ROB_W-1:0] rs2_tag,
    input  logic             ren_flg,
    input  logic [4:0]       ren_rd,
    input  logic [ROB_W-1:0] ren_tag,
    input  logic             cmt_flg,
    input  logic [4:0]       cmt_rd,
    input  logic [31:0]      cmt_res,
    input  logic [ROB_W-1:0] cmt_tag,
    input  logic             flush,
    output logic [5:0]       busy_cnt
);

    localparam int unsigned NREG  = 32;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    logic [XLEN-1:0]  r_val [NREG];
    logic [ROB_W-1:0] r_tag [NREG];
    logic [CNT_W-1:0] r_busy_cnt;

    logic w_ren_ok;
    logic w_cmt_ok;
    logic w_cmt_match;
    logic w_inc;
    logic w_dec;
    logic w_byp1;
    logic w_byp2;

    // Qualify events: rdy gates everything, x0 is never touched, flush kills renames
    always_comb begin
        w_ren_ok    = rdy && ren_flg && (ren_rd != 5'd0) && !flush;
        w_cmt_ok    = rdy && cmt_flg && (cmt_rd != 5'd0);
        w_cmt_match = w_cmt_ok && (r_tag[cmt_rd] == cmt_tag);
        w_inc       = w_ren_ok && (r_tag[ren_rd] == '0);
        w_dec       = w_cmt_match && (r_tag[cmt_rd] != '0)
                      && !(w_ren_ok && (ren_rd == cmt_rd));
        w_byp1      = w_cmt_match && (rs1_idx == cmt_rd);
        w_byp2      = w_cmt_match && (rs2_idx == cmt_rd);
    end

    // Read ports with commit bypass; x0 always reads as zero / not renamed
    always_comb begin
        rs1_val = r_val[rs1_idx];
        rs1_tag = r_tag[rs1_idx];
        rs2_val = r_val[rs2_idx];
        rs2_tag = r_tag[rs2_idx];
        if (w_byp1) begin
            rs1_val = cmt_res;
            rs1_tag = '0;
        end
        if (w_byp2) begin
            rs2_val = cmt_res;
            rs2_tag = '0;
        end
        if (rs1_idx == 5'd0) begin
            rs1_val = '0;
            rs1_tag = '0;
        end
        if (rs2_idx == 5'd0) begin
            rs2_val = '0;
            rs2_tag = '0;
        end
    end

    // Value and tag storage; a rename overrides a same-register tag clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (rdy) begin
            if (w_cmt_ok) begin
                r_val[cmt_rd] <= cmt_res;
            end
            if (flush) begin
                for (int unsigned i = 0; i < NREG; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_cmt_match) begin
                    r_tag[cmt_rd] <= '0;
                end
                if (w_ren_ok) begin
                    r_tag[ren_rd] <= ren_tag;
                end
            end
        end
    end

    // Incremental count of renamed registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy_cnt <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy_cnt <= '0;
            end else begin
                r_busy_cnt <= r_busy_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed scenarios followed by random traffic,
// all checked against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_rename_file;

    localparam int unsigned ROB_W = 5;

    logic             clk = 1'b0;
    logic             rst, rdy, ren_flg, cmt_flg, flush;
    logic [4:0]       rs1_idx, rs2_idx, ren_rd, cmt_rd;
    logic [31:0]      rs1_val, rs2_val, cmt_res;
    logic [ROB_W-1:0] rs1_tag, rs2_tag, ren_tag, cmt_tag;
    logic [5:0]       busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_val [32];
    int          m_tag [32];

    reg_rename_file #(.ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .ren_flg(ren_flg), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .cmt_flg(cmt_flg), .cmt_rd(cmt_rd), .cmt_res(cmt_res), .cmt_tag(cmt_tag),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    // Model: a register that a matching commit is retiring reads the committed value
    function automatic logic bypass(input logic [4:0] idx);
        return rdy && cmt_flg && (cmt_rd != 0) && (idx == cmt_rd) && (m_tag[idx] == int'(cmt_tag));
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (bypass(idx)) return cmt_res;
        return m_val[idx];
    endfunction

    function automatic logic [31:0] exp_tag(input logic [4:0] idx);
        if (idx == 0 || bypass(idx)) return 32'd0;
        return 32'(m_tag[idx]);
    endfunction

    function automatic int busy_model();
        int c = 0;
        for (int i = 1; i < 32; i++) if (m_tag[i] != 0) c++;
        return c;
    endfunction

    // Model: apply the rules of one clock edge to the architectural state
    task automatic model_edge();
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 32'd0;
                m_tag[i] = 0;
            end
        end else if (rdy) begin
            if (cmt_flg && cmt_rd != 0) begin
                m_val[cmt_rd] = cmt_res;
                if (!flush && m_tag[cmt_rd] == int'(cmt_tag)) m_tag[cmt_rd] = 0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_tag[i] = 0;
            end else if (ren_flg && ren_rd != 0) begin
                m_tag[ren_rd] = int'(ren_tag);
            end
        end
    endtask

    task automatic idle();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ren_flg = 1'b0; ren_rd = 5'd0; ren_tag = '0;
        cmt_flg = 1'b0; cmt_rd = 5'd0; cmt_res = 32'd0; cmt_tag = '0;
    endtask

    // One cycle: check reads before the edge, update model at the edge, check count after
    task automatic step();
        @(negedge clk);
        chk($sformatf("rs1_val[x%0d]", rs1_idx), rs1_val, exp_val(rs1_idx));
        chk($sformatf("rs1_tag[x%0d]", rs1_idx), 32'(rs1_tag), exp_tag(rs1_idx));
        chk($sformatf("rs2_val[x%0d]", rs2_idx), rs2_val, exp_val(rs2_idx));
        chk($sformatf("rs2_tag[x%0d]", rs2_idx), 32'(rs2_tag), exp_tag(rs2_idx));
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_cnt", 32'(busy_cnt), 32'(busy_model()));
    endtask

    task automatic check_all();
        for (int i = 0; i < 16; i++) begin
            idle();
            rs1_idx = 5'(i);
            rs2_idx = 5'(i + 16);
            step();
        end
    endtask

    task automatic do_reset();
        idle(); rst = 1'b0; step(); idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin m_val[i] = 32'd0; m_tag[i] = 0; end
        idle(); rst = 1'b0; rs1_idx = 5'd0; rs2_idx = 5'd0;
        @(posedge clk); #1;
        step();
        check_all();

        // basic rename then commit
        idle(); rs1_idx = 5'd5; rs2_idx = 5'd5; ren_flg = 1'b1; ren_rd = 5'd5; ren_tag = 5'd3;
        step();
        idle(); rs1_idx = 5'd5; step();
        chk("ren_x5_busy", 32'(busy_cnt), 32'd1);
        idle(); rs1_idx = 5'd5;
        cmt_flg = 1'b1; cmt_rd = 5'd5; cmt_tag = 5'd3; cmt_res = 32'hDEADBEEF;
        #1;
        chk("cmt_x5_byp_val", rs1_val, 32'hDEADBEEF);
        chk("cmt_x5_byp_tag", 32'(rs1_tag), 32'd0);
        step();
        idle(); step();
        chk("cmt_x5_busy", 32'(busy_cnt), 32'd0);

        // stale commit keeps the younger tag
        do_reset();
        idle(); ren_flg = 1'b1; ren_rd = 5'd7; ren_tag = 5'd2; step();
        idle(); ren_flg = 1'b1; ren_rd = 5'd7; ren_tag = 5'd4; step();
        idle(); rs1_idx = 5'd7; cmt_flg = 1'b1; cmt_rd = 5'd7; cmt_tag = 5'd2; cmt_res = 32'h11; step();
        idle(); rs1_idx = 5'd7; #1;
        chk("stale_val", rs1_val, 32'h11);
        chk("stale_tag", 32'(rs1_tag), 32'd4);
        chk("stale_busy", 32'(busy_cnt), 32'd1);
        step();

        // same-cycle rename and commit on one register
        do_reset();
        idle(); ren_flg = 1'b1; ren_rd = 5'd9; ren_tag = 5'd6; step();
        idle(); rs1_idx = 5'd9; cmt_flg = 1'b1; cmt_rd = 5'd9; cmt_tag = 5'd6; cmt_res = 32'h22;
        ren_flg = 1'b1; ren_rd = 5'd9; ren_tag = 5'd8; step();
        idle(); rs1_idx = 5'd9; #1;
        chk("rc_val", rs1_val, 32'h22);
        chk("rc_tag", 32'(rs1_tag), 32'd8);
        chk("rc_busy", 32'(busy_cnt), 32'd1);
        step();

        // flush with concurrent commit and rename
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            idle(); ren_flg = 1'b1; ren_rd = 5'(i); ren_tag = 5'(i); step();
        end
        idle(); flush = 1'b1; cmt_flg = 1'b1; cmt_rd = 5'd2; cmt_tag = 5'd2; cmt_res = 32'h33;
        ren_flg = 1'b1; ren_rd = 5'd6; ren_tag = 5'd5; step();
        idle(); rs1_idx = 5'd2; rs2_idx = 5'd6; #1;
        chk("flush_x2_val", rs1_val, 32'h33);
        chk("flush_x6_tag", 32'(rs2_tag), 32'd0);
        chk("flush_busy", 32'(busy_cnt), 32'd0);
        check_all();

        // x0 writes ignored; rdy low holds state
        idle(); ren_flg = 1'b1; ren_rd = 5'd0; ren_tag = 5'd7;
        cmt_flg = 1'b1; cmt_rd = 5'd0; cmt_res = 32'h44; step();
        idle(); rs1_idx = 5'd0; #1;
        chk("x0_val", rs1_val, 32'd0);
        chk("x0_tag", 32'(rs1_tag), 32'd0);
        idle(); rdy = 1'b0; ren_flg = 1'b1; ren_rd = 5'd3; ren_tag = 5'd9; step();
        idle(); rs1_idx = 5'd3; #1;
        chk("rdy_x3_tag", 32'(rs1_tag), 32'd0);
        step();

        // reset mid-operation
        idle(); cmt_flg = 1'b1; cmt_rd = 5'd10; cmt_res = 32'h55; step();
        for (int i = 11; i <= 13; i++) begin
            idle(); ren_flg = 1'b1; ren_rd = 5'(i); ren_tag = 5'(i); step();
        end
        chk("pre_rst_busy", 32'(busy_cnt), 32'd3);
        do_reset();
        chk("rst_busy", 32'(busy_cnt), 32'd0);
        check_all();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst     = ($urandom_range(0, 99) != 0);
            rdy     = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            ren_flg = 1'($urandom);
            ren_rd  = 5'($urandom);
            ren_tag = ROB_W'($urandom_range(1, 31));
            cmt_flg = 1'($urandom);
            cmt_rd  = 5'($urandom);
            cmt_res = $urandom;
            cmt_tag = ($urandom_range(0, 2) != 0) ? ROB_W'(m_tag[cmt_rd]) : ROB_W'($urandom);
            rs1_idx = ($urandom_range(0, 1) != 0) ? cmt_rd : 5'($urandom);
            rs2_idx = 5'($urandom);
            step();
        end
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_rename_file.md
REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 SHALL have parameter ROB_W, default 5, meaning ROB tag width; tag 0 means "not renamed", and valid tags are 1..2^ROB_W-1.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port rdy  input  1  ready; while low, all state is held.
REQ-005 SHALL have port rs1_idx  input  5  first source register index.
REQ-006 SHALL have port rs2_idx  input  5  second source register index.
REQ-007 SHALL have port rs1_val  output  32  architectural value of rs1_idx (combinational).
REQ-008 SHALL have port rs1_tag  output  ROB_W  ROB tag owning rs1_idx; 0 if not renamed (combinational).
REQ-009 SHALL have port rs2_val  output  32  same as rs1_val, for rs2_idx.
REQ-010 SHALL have port rs2_tag  output  ROB_W  same as rs1_tag, for rs2_idx.
REQ-011 SHALL have port ren_flg  input  1  rename request from dispatch.
REQ-012 SHALL have port ren_rd  input  5  destination register being renamed.
REQ-013 SHALL have port ren_tag  input  ROB_W  ROB entry allocated to the destination.
REQ-014 SHALL have port cmt_flg  input  1  register commit from the ROB.
REQ-015 SHALL have port cmt_rd  input  5  committed destination register.
REQ-016 SHALL have port cmt_res  input  32  committed value.
REQ-017 SHALL have port cmt_tag  input  ROB_W  ROB entry being committed.
REQ-018 SHALL have port flush  input  1  mispredict/JALR reset; discards all renames.
REQ-019 SHALL have port busy_cnt  output  6  registered count of registers with tag != 0.

Function
REQ-020 SHALL hold 32 x 32-bit values and 32 x ROB_W-bit tags; x0 SHALL read value 0 and tag 0, and SHALL ignore every write and rename to it.
REQ-021 SHALL, on cmt_flg with cmt_rd != 0, write cmt_res into value[cmt_rd] in the same cycle, regardless of tag match.
REQ-022 SHALL clear tag[cmt_rd] on commit only when tag[cmt_rd] == cmt_tag; otherwise the tag is kept, because a younger rename owns the register.
REQ-023 SHALL, on ren_flg with ren_rd != 0, set tag[ren_rd] <= ren_tag.
REQ-024 SHALL give rename priority over tag clear when ren_rd == cmt_rd in the same cycle: the value is written and the tag becomes ren_tag.
REQ-025 SHALL bypass commits on reads: if cmt_flg, rsN_idx == cmt_rd != 0 and tag[rsN_idx] == cmt_tag, then rsN_val = cmt_res and rsN_tag = 0 in that cycle.
REQ-026 SHALL NOT bypass renames on reads: a same-cycle rename is not visible until the next cycle.
REQ-027 SHALL, on flush, clear all tags to 0 and ignore ren_flg; a same-cycle cmt_flg SHALL still write its value.
REQ-028 SHALL keep busy_cnt equal to the number of nonzero tags after each edge: +1 for a rename of a register whose tag was 0, -1 for a tag-clearing commit, net 0 for simultaneous events on the same register, and 0 on flush.
REQ-029 SHALL, while rdy is low, ignore ren_flg, cmt_flg and flush, while read outputs keep tracking the current state.
REQ-030 SHALL require ren_tag != 0 when ren_flg is asserted; behaviour with ren_tag == 0 is undefined.

Reset
REQ-031 SHALL, on a rising edge with rst low, clear all values to 0, all tags to 0 and busy_cnt to 0; rst takes priority over rdy and flush.
REQ-032 SHALL, immediately after reset, present rs1_val = rs2_val = 0 and rs1_tag = rs2_tag = 0 for every index.

Verification
REQ-033 SHALL be verified for basic rename/commit: ren x5 tag 3; next cycle read x5 -> tag 3; cmt x5 tag 3 res 0xDEADBEEF -> same-cycle read val 0xDEADBEEF tag 0; next cycle tag 0 and busy_cnt 0.
REQ-034 SHALL be verified for a stale commit: ren x7 tag 2, then ren x7 tag 4, then cmt x7 tag 2 res 0x11 -> value 0x11, tag remains 4, busy_cnt 1.
REQ-035 SHALL be verified for same-cycle rename and commit: x9 tag 6 outstanding; cmt x9 tag 6 res 0x22 together with ren x9 tag 8 -> value 0x22, tag 8, busy_cnt unchanged at 1.
REQ-036 SHALL be verified for flush: rename x1..x4 with tags 1..4; flush with cmt x2 tag 2 res 0x33 and ren x6 tag 5 -> all tags 0, x2 = 0x33, x6 tag 0, busy_cnt 0.
REQ-037 SHALL be verified for x0 and rdy: ren x0 tag 7 and cmt x0 res 0x44 -> x0 reads 0 with tag 0; with rdy low, ren x3 tag 9 -> x3 tag stays 0.
REQ-038 SHALL be verified for reset mid-operation: 3 renames outstanding, then rst low for one edge -> all tags 0, all values 0, busy_cnt 0.
